dual_rail_rx_monitor: RTL

//  Receiving end of a complementary (dual-rail) signal pair: rail_p carries data, rail_n its inverse.
//  - Synchronises both rails, decodes the data bit and filters short equal-rail glitches.
//  - Declares a fault when the rails stay equal too long; keeps a sticky fault flag and a saturating fault count.
//  - Sits at the link input, ahead of any logic that consumes the decoded bit.

---
 rtl/dual_rail_rx_monitor_if.sv | 24 ++
 rtl/dual_rail_rx_monitor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dual_rail_rx_monitor_if.sv
// Signal bundle between a dual-rail link driver and the receive monitor.
// The master drives the rails and the clear pulse; the slave returns the decoded status.
interface dual_rail_rx_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             rail_p;
  logic             rail_n;
  logic             clr_i;
  logic             bit_o;
  logic             edge_o;
  logic             fault_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [1:0]       state_o;

  modport master (
    output rail_p, rail_n, clr_i,
    input  bit_o, edge_o, fault_o, err_cnt_o, state_o
  );

  modport slave (
    input  rail_p, rail_n, clr_i,
    output bit_o, edge_o, fault_o, err_cnt_o, state_o
  );
endinterface

// File: rtl/dual_rail_rx_monitor.sv
// Dual-rail receiver: synchronises both rails, decodes the bit, filters short equal-rail
// glitches and records faults. Optional run-time checks are enabled with DRX_ASSERT_EN.
module dual_rail_rx_monitor #(
  parameter int GLITCH_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dual_rail_rx_monitor_if.slave drx
);
  localparam int               GW      = $clog2(GLITCH_CYC + 1);
  localparam logic [GW-1:0]    G_MAX   = GW'(GLITCH_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VALID  = 2'd1,
    GLITCH = 2'd2,
    FAULT  = 2'd3
  } state_t;

  logic             r_p1, r_p2, r_n1, r_n2;
  state_t           r_state, w_state_next;
  logic [GW-1:0]    r_gcnt, w_gcnt_next;
  logic             r_bit, w_bit_next;
  logic             r_edge, w_edge_next;
  logic             r_fault, w_fault_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_valid;
  logic             w_fault_entry;

  assign w_valid = r_p2 ^ r_n2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p1    <= 1'b0;
      r_p2    <= 1'b0;
      r_n1    <= 1'b0;
      r_n2    <= 1'b0;
      r_state <= IDLE;
      r_gcnt  <= '0;
      r_bit   <= 1'b0;
      r_edge  <= 1'b0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_p1    <= drx.rail_p;
      r_p2    <= r_p1;
      r_n1    <= drx.rail_n;
      r_n2    <= r_n1;
      r_state <= w_state_next;
      r_gcnt  <= w_gcnt_next;
      r_bit   <= w_bit_next;
      r_edge  <= w_edge_next;
      r_fault <= w_fault_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_gcnt_next   = r_gcnt;
    w_bit_next    = r_bit;
    w_edge_next   = 1'b0;
    w_fault_next  = r_fault;
    w_cnt_next    = r_cnt;
    w_fault_entry = 1'b0;
    if (drx.clr_i) begin
      w_fault_next = 1'b0;
      w_cnt_next   = '0;
    end
    case (r_state)
      IDLE: begin
        // First capture after reset never produces an edge pulse.
        if (w_valid) begin
          w_state_next = VALID;
          w_bit_next   = r_p2;
        end
      end
      VALID: begin
        if (w_valid) begin
          w_bit_next  = r_p2;
          w_edge_next = r_p2 ^ r_bit;
        end else begin
          w_state_next = GLITCH;
          w_gcnt_next  = GW'(1);
        end
      end
      GLITCH: begin
        if (w_valid) begin
          w_state_next = VALID;
          w_bit_next   = r_p2;
          w_edge_next  = r_p2 ^ r_bit;
          w_gcnt_next  = '0;
        end else if (r_gcnt < G_MAX) begin
          w_gcnt_next = r_gcnt + GW'(1);
        end else begin
          w_state_next  = FAULT;
          w_fault_entry = 1'b1;
        end
      end
      FAULT: begin
        if (w_valid) begin
          w_state_next = VALID;
          w_bit_next   = r_p2;
          w_edge_next  = r_p2 ^ r_bit;
          w_gcnt_next  = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // A fault entry overrides a coincident clear, so the count restarts at one.
    if (w_fault_entry) begin
      w_fault_next = 1'b1;
      w_cnt_next   = (w_cnt_next == CNT_MAX) ? CNT_MAX : w_cnt_next + CNT_W'(1);
    end
  end

  assign drx.bit_o     = r_bit;
  assign drx.edge_o    = r_edge;
  assign drx.fault_o   = r_fault;
  assign drx.err_cnt_o = r_cnt;
  assign drx.state_o   = r_state;

`ifdef DRX_ASSERT_EN
  logic r_seen_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seen_valid <= 1'b0;
    end else begin
      if (w_valid) r_seen_valid <= 1'b1;
      if (w_fault_entry)
        $error("dual_rail_rx_monitor: fault entry at %0t, err_cnt_o=%0d", $time, w_cnt_next);
    end
  end

  always_comb begin
    assert #0 (!r_fault || (r_cnt != '0));
    assert #0 ((r_state != GLITCH) || ((r_gcnt >= GW'(1)) && (r_gcnt <= G_MAX)));
    assert #0 (!r_seen_valid || (r_state != IDLE));
  end
`else
  // Default build carries no checking logic; the datapath above is unchanged.
`endif
endmodule
